// File: rtl/dwt_tr_pkg.sv
// rtl/dwt_tr_pkg.sv - shared constants for the DWT column-to-row transpose stage
package dwt_tr_pkg;

   localparam int   TR_DATA_W         = 16;

   localparam logic TR_MODE_TRANSPOSE = 1'b0;
   localparam logic TR_MODE_BYPASS    = 1'b1;

   localparam logic TR_SEL_L          = 1'b0;
   localparam logic TR_SEL_H          = 1'b1;

endpackage

// File: rtl/dwt_tr_outreg.sv
// rtl/dwt_tr_outreg.sv - registered output pair with load/stall control
module dwt_tr_outreg
   import dwt_tr_pkg::*;
#(
   parameter int DATA_W = TR_DATA_W
) (
   input  logic              clk_tr,
   input  logic              rst_syn,
   input  logic              dwt_work,
   input  logic              load,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic              sel_d,
   input  logic              last_d,
   output logic [DATA_W-1:0] out1,
   output logic [DATA_W-1:0] out2,
   output logic              sel,
   output logic              last,
   output logic              vld
);

   // Data, sel and last hold their value between loads; only vld is a per-cycle strobe.
   always_ff @(posedge clk_tr) begin
      if (rst_syn) begin
         out1 <= '0;
         out2 <= '0;
         sel  <= TR_SEL_L;
         last <= 1'b0;
         vld  <= 1'b0;
      end else if (!dwt_work) begin
         vld  <= 1'b0;
      end else begin
         vld  <= load;
         if (load) begin
            out1 <= d1;
            out2 <= d2;
            sel  <= sel_d;
            last <= last_d;
         end
      end
   end

endmodule

// File: rtl/transpose_pair_gen.sv
// rtl/transpose_pair_gen.sv - 2-lane L/H pair transpose with bypass; TR_GAP_FLUSH_EN flushes a held pair on an input gap
module transpose_pair_gen
   import dwt_tr_pkg::*;
#(
   parameter int                DATA_W  = TR_DATA_W,
   parameter logic [DATA_W-1:0] PAD_VAL = '0
) (
   input  logic              clk_tr,
   input  logic              rst_syn,
   input  logic              dwt_work,
   input  logic              col_out_vld,
   input  logic [DATA_W-1:0] col_ldata,
   input  logic [DATA_W-1:0] col_hdata,
   input  logic              col_last,
   input  logic              tr_mode,
   output logic [DATA_W-1:0] atrcol_out1,
   output logic [DATA_W-1:0] atrcol_out2,
   output logic              atrcol_vld,
   output logic              atrcol_sel,
   output logic              atrcol_last
);

   logic [DATA_W-1:0] hold_l, hold_h, hold_l_n, hold_h_n;
   logic              hold_vld, hold_tail, hold_vld_n, hold_tail_n;
   logic [DATA_W-1:0] pend_h0, pend_h1, pend_h0_n, pend_h1_n;
   logic              pend_vld, pend_last, pend_vld_n, pend_last_n;
   logic              mode_q, mode_n;

   logic              blk_empty, mode_eff, tail_eff;
   logic              o_load, o_sel, o_last;
   logic [DATA_W-1:0] o_d1, o_d2;

   // A new mode is only adopted between blocks so a half-built pair is never split.
   assign blk_empty = !hold_vld && !pend_vld;
   assign mode_eff  = blk_empty ? tr_mode : mode_q;

`ifdef TR_GAP_FLUSH_EN
   assign tail_eff  = hold_tail || !col_out_vld;
`else
   assign tail_eff  = hold_tail;
`endif

   always_comb begin
      hold_l_n    = hold_l;
      hold_h_n    = hold_h;
      hold_vld_n  = hold_vld;
      hold_tail_n = hold_tail;
      pend_h0_n   = pend_h0;
      pend_h1_n   = pend_h1;
      pend_vld_n  = pend_vld;
      pend_last_n = pend_last;
      mode_n      = blk_empty ? tr_mode : mode_q;
      o_load      = 1'b0;
      o_d1        = '0;
      o_d2        = '0;
      o_sel       = TR_SEL_L;
      o_last      = 1'b0;

      if (mode_eff == TR_MODE_BYPASS) begin
         if (col_out_vld) begin
            o_load = 1'b1;
            o_d1   = col_ldata;
            o_d2   = col_hdata;
            o_last = col_last;
         end
      end else if (pend_vld) begin
         o_load     = 1'b1;
         o_d1       = pend_h0;
         o_d2       = pend_h1;
         o_sel      = TR_SEL_H;
         o_last     = pend_last;
         pend_vld_n = 1'b0;
         if (col_out_vld) begin
            hold_l_n    = col_ldata;
            hold_h_n    = col_hdata;
            hold_vld_n  = 1'b1;
            hold_tail_n = col_last;
         end
      end else if (hold_vld && !tail_eff && col_out_vld) begin
         o_load      = 1'b1;
         o_d1        = hold_l;
         o_d2        = col_ldata;
         pend_h0_n   = hold_h;
         pend_h1_n   = col_hdata;
         pend_last_n = col_last;
         pend_vld_n  = 1'b1;
         hold_vld_n  = 1'b0;
         hold_tail_n = 1'b0;
      end else if (hold_vld && tail_eff) begin
         // Odd tail: pad the missing partner and force last on the H-pair.
         o_load      = 1'b1;
         o_d1        = hold_l;
         o_d2        = PAD_VAL;
         pend_h0_n   = hold_h;
         pend_h1_n   = PAD_VAL;
         pend_last_n = 1'b1;
         pend_vld_n  = 1'b1;
         hold_vld_n  = 1'b0;
         hold_tail_n = 1'b0;
         if (col_out_vld) begin
            hold_l_n    = col_ldata;
            hold_h_n    = col_hdata;
            hold_vld_n  = 1'b1;
            hold_tail_n = col_last;
         end
      end else if (col_out_vld) begin
         hold_l_n    = col_ldata;
         hold_h_n    = col_hdata;
         hold_vld_n  = 1'b1;
         hold_tail_n = col_last;
      end
   end

   always_ff @(posedge clk_tr) begin
      if (rst_syn) begin
         hold_l    <= '0;
         hold_h    <= '0;
         hold_vld  <= 1'b0;
         hold_tail <= 1'b0;
         pend_h0   <= '0;
         pend_h1   <= '0;
         pend_vld  <= 1'b0;
         pend_last <= 1'b0;
         mode_q    <= TR_MODE_TRANSPOSE;
      end else if (dwt_work) begin
         hold_l    <= hold_l_n;
         hold_h    <= hold_h_n;
         hold_vld  <= hold_vld_n;
         hold_tail <= hold_tail_n;
         pend_h0   <= pend_h0_n;
         pend_h1   <= pend_h1_n;
         pend_vld  <= pend_vld_n;
         pend_last <= pend_last_n;
         mode_q    <= mode_n;
      end
   end

   dwt_tr_outreg #(.DATA_W(DATA_W)) u_outreg (
      .clk_tr   (clk_tr),
      .rst_syn  (rst_syn),
      .dwt_work (dwt_work),
      .load     (o_load),
      .d1       (o_d1),
      .d2       (o_d2),
      .sel_d    (o_sel),
      .last_d   (o_last),
      .out1     (atrcol_out1),
      .out2     (atrcol_out2),
      .sel      (atrcol_sel),
      .last     (atrcol_last),
      .vld      (atrcol_vld)
   );

endmodule
